// File: rtl/vpu_pkg.sv
// Shared types for the VPU execute sequencer: the micro-op format, functional-unit
// selector, sequencer states and the LMUL-to-register-group mapping.
package vpu_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_LSU = 2'd3
    } fu_e;

    typedef struct packed {
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [2:0] vlmul;
        fu_e        fu;
    } VPU_uOP_t;

    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } seq_state_e;

    // Fractional and reserved encodings occupy a single register group.
    function automatic logic [3:0] lmul_to_groups(input logic [2:0] vlmul);
        case (vlmul)
            3'b000:  return 4'd1;
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/vpu_outstanding_counter.sv
// Up/down count of parts issued to the FU but not yet completed, with a full flag.
// Decrements at zero are dropped so late completions after a reset are harmless.
module vpu_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [CNT_W-1:0] count_q;

    assign full_o  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            count_q <= count_q + CNT_W'(1);
        end else if (!inc_i && dec_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/vpu_exe_sequencer.sv
// Accepts dispatched VPU micro-ops and expands each into 1/2/4/8 register-group parts
// for the execute FU, throttled by the number of parts still in flight.
module vpu_exe_sequencer
    import vpu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dispatch_valid_i,
    input  VPU_uOP_t         dispatch_entry_i,
    output logic             dispatch_ready_o,
    output logic             fu_req_valid_o,
    output VPU_uOP_t         fu_req_o,
    input  logic             fu_req_ready_i,
    output logic             fu_last_o,
    input  logic             fu_done_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] outstanding_o
);

    seq_state_e       state_q, state_d;
    VPU_uOP_t         uop_q, uop_d;
    logic [2:0]       part_q, part_d;
    logic [3:0]       groups;
    logic             last_part;
    logic             issue_valid;
    logic             fu_hs;
    logic             cap_full;
    logic [CNT_W-1:0] outstanding;

    assign groups      = lmul_to_groups(uop_q.vlmul);
    assign last_part   = ({1'b0, part_q} == (groups - 4'd1));
    assign issue_valid = (state_q == SEQ_ISSUE) && !cap_full;
    assign fu_hs       = issue_valid && fu_req_ready_i;

    vpu_outstanding_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_outstanding (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (fu_hs),
        .dec_i  (fu_done_i),
        .count_o(outstanding),
        .full_o (cap_full)
    );

    // Finishing the last part while a new uop waits takes it in the same cycle,
    // so consecutive uops stream without a bubble.
    always_comb begin
        state_d          = state_q;
        uop_d            = uop_q;
        part_d           = part_q;
        dispatch_ready_o = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                dispatch_ready_o = 1'b1;
                if (dispatch_valid_i) begin
                    uop_d   = dispatch_entry_i;
                    part_d  = 3'd0;
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (fu_hs) begin
                    if (!last_part) begin
                        part_d = part_q + 3'd1;
                    end else if (dispatch_valid_i) begin
                        dispatch_ready_o = 1'b1;
                        uop_d            = dispatch_entry_i;
                        part_d           = 3'd0;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            uop_q   <= '0;
            part_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;
            part_q  <= part_d;
        end
    end

    // Register indices advance with the part number; 5-bit wrap is intentional.
    always_comb begin
        fu_req_o     = uop_q;
        fu_req_o.vd  = uop_q.vd  + {2'b00, part_q};
        fu_req_o.vs1 = uop_q.vs1 + {2'b00, part_q};
        fu_req_o.vs2 = uop_q.vs2 + {2'b00, part_q};
    end

    assign fu_req_valid_o = issue_valid;
    assign fu_last_o      = (state_q == SEQ_ISSUE) && last_part;
    assign busy_o         = (state_q != SEQ_IDLE) || (outstanding != '0);
    assign outstanding_o  = outstanding;

endmodule

// File: tb/tb_vpu_exe_sequencer.sv
// Self-checking bench for vpu_exe_sequencer: a queue-based reference model of the
// expected part stream and in-flight count, plus directed and randomized scenarios.
module tb_vpu_exe_sequencer;
    import vpu_pkg::*;

    localparam int MAXO = 2;
    localparam int OW   = $clog2(MAXO + 1);

    logic          clk_i;
    logic          rst_i;
    logic          dispatch_valid_i;
    VPU_uOP_t      dispatch_entry_i;
    logic          dispatch_ready_o;
    logic          fu_req_valid_o;
    VPU_uOP_t      fu_req_o;
    logic          fu_req_ready_i;
    logic          fu_last_o;
    logic          fu_done_i;
    logic          busy_o;
    logic [OW-1:0] outstanding_o;

    vpu_exe_sequencer #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dispatch_valid_i(dispatch_valid_i),
        .dispatch_entry_i(dispatch_entry_i),
        .dispatch_ready_o(dispatch_ready_o),
        .fu_req_valid_o  (fu_req_valid_o),
        .fu_req_o        (fu_req_o),
        .fu_req_ready_i  (fu_req_ready_i),
        .fu_last_o       (fu_last_o),
        .fu_done_i       (fu_done_i),
        .busy_o          (busy_o),
        .outstanding_o   (outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        VPU_uOP_t uop;
        logic     last;
    } part_t;

    typedef struct {
        VPU_uOP_t uop;
        logic     last;
        logic     rdy;
        int       cyc;
    } log_t;

    part_t q[$];
    log_t  plog[$];
    int    cnt;
    int    cyc;
    int    rdy_low;
    int    vectors;
    int    fails;
    logic  hs_seen;
    logic  acc_seen;
    logic  auto_done;
    logic  toggle_rdy;
    logic  rand_mode;

    function automatic VPU_uOP_t mk(input int vd, input int vs1, input int vs2,
                                    input logic [2:0] lm, input fu_e fu);
        VPU_uOP_t u;
        u.vd    = 5'(vd);
        u.vs1   = 5'(vs1);
        u.vs2   = 5'(vs2);
        u.vlmul = lm;
        u.fu    = fu;
        return u;
    endfunction

    function automatic int n_groups(input logic [2:0] lm);
        return lm[2] ? 1 : (1 << lm[1:0]);
    endfunction

    // Reference model evaluated mid-cycle; its updates describe the following rising edge.
    always @(negedge clk_i) begin
        logic ev, er, hs, acc;
        cyc++;
        if (rst_i) begin
            q.delete();
            cnt      = 0;
            hs_seen  = 1'b0;
            acc_seen = 1'b0;
        end else begin
            ev = (q.size() > 0) && (cnt < MAXO);
            er = (q.size() == 0) ||
                 ((q.size() == 1) && ev && fu_req_ready_i && dispatch_valid_i);
            vectors++;
            if (fu_req_valid_o !== ev) begin
                fails++;
                $display("FAIL model_valid cyc=%0d: got %b expected %b", cyc, fu_req_valid_o, ev);
            end
            vectors++;
            if (dispatch_ready_o !== er) begin
                fails++;
                $display("FAIL model_ready cyc=%0d: got %b expected %b", cyc, dispatch_ready_o, er);
            end
            vectors++;
            if (outstanding_o !== OW'(cnt)) begin
                fails++;
                $display("FAIL model_outstanding cyc=%0d: got %0d expected %0d", cyc, outstanding_o, cnt);
            end
            vectors++;
            if (busy_o !== ((q.size() > 0) || (cnt != 0))) begin
                fails++;
                $display("FAIL model_busy cyc=%0d: got %b expected %b", cyc, busy_o,
                         ((q.size() > 0) || (cnt != 0)));
            end
            if (ev) begin
                vectors++;
                if (fu_req_o !== q[0].uop || fu_last_o !== q[0].last) begin
                    fails++;
                    $display("FAIL model_part cyc=%0d: got %h/last=%b expected %h/last=%b",
                             cyc, fu_req_o, fu_last_o, q[0].uop, q[0].last);
                end
            end
            hs  = ev && fu_req_ready_i;
            acc = er && dispatch_valid_i;
            if (hs) begin
                plog.push_back('{q[0].uop, q[0].last, dispatch_ready_o, cyc});
                void'(q.pop_front());
            end
            if (acc) begin
                int g;
                g = n_groups(dispatch_entry_i.vlmul);
                for (int k = 0; k < g; k++) begin
                    part_t p;
                    p.uop     = dispatch_entry_i;
                    p.uop.vd  = 5'(dispatch_entry_i.vd + k);
                    p.uop.vs1 = 5'(dispatch_entry_i.vs1 + k);
                    p.uop.vs2 = 5'(dispatch_entry_i.vs2 + k);
                    p.last    = (k == g - 1);
                    q.push_back(p);
                end
            end
            if (hs && !fu_done_i) cnt++;
            else if (!hs && fu_done_i && cnt > 0) cnt--;
            if (dispatch_ready_o === 1'b0) rdy_low++;
            hs_seen  = hs;
            acc_seen = acc;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_mode) begin
            fu_req_ready_i = ($urandom_range(0, 3) != 0);
            fu_done_i      = 1'($urandom_range(0, 1));
        end else begin
            if (auto_done)  fu_done_i = hs_seen;
            if (toggle_rdy) fu_req_ready_i = ~fu_req_ready_i;
        end
    endtask

    task automatic dispatch(input VPU_uOP_t e);
        int n;
        n = 0;
        dispatch_entry_i = e;
        dispatch_valid_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_seen && n < 60);
        vectors++;
        if (!acc_seen) begin
            fails++;
            $display("FAIL dispatch_accept: not accepted after %0d cycles, required acceptance", n);
        end
        dispatch_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || cnt != 0) && n < 400) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL drain_idle: busy=%b after %0d cycles, required 0", busy_o, n);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        vectors++;
        if (fu_req_valid_o !== 1'b0 || fu_last_o !== 1'b0 || fu_req_o !== '0) begin
            fails++;
            $display("FAIL reset_fu: valid=%b last=%b req=%h, required 0/0/0", fu_req_valid_o, fu_last_o, fu_req_o);
        end
        vectors++;
        if (dispatch_ready_o !== 1'b1 || busy_o !== 1'b0 || outstanding_o !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b busy=%b out=%0d, required 1/0/0", dispatch_ready_o, busy_o, outstanding_o);
        end
        tick();
    endtask

    task automatic test_single();
        plog.delete();
        auto_done      = 1'b1;
        fu_req_ready_i = 1'b1;
        rdy_low        = 0;
        dispatch(mk(3, 4, 5, 3'b000, FU_ALU));
        drain();
        vectors++;
        if (plog.size() != 1 || plog[0].uop.vd !== 5'd3 || plog[0].last !== 1'b1) begin
            fails++;
            $display("FAIL single_part: count=%0d, required 1 part vd=3 last=1", plog.size());
        end
        vectors++;
        if (rdy_low != 1) begin
            fails++;
            $display("FAIL single_ready_drop: low for %0d cycles, required 1", rdy_low);
        end
    endtask

    task automatic test_lmul8();
        plog.delete();
        dispatch(mk(8, 0, 16, 3'b011, FU_MUL));
        dispatch(mk(1, 2, 3, 3'b000, FU_ALU));
        drain();
        vectors++;
        if (plog.size() != 9) begin
            fails++;
            $display("FAIL lmul8_count: got %0d parts, required 9", plog.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (plog[k].uop.vd !== 5'(8 + k) || plog[k].uop.vs2 !== 5'(16 + k) ||
                    plog[k].last !== (k == 7) || (k > 0 && plog[k].cyc != plog[k-1].cyc + 1)) begin
                    fails++;
                    $display("FAIL lmul8_part%0d: vd=%0d vs2=%0d last=%b, required vd=%0d vs2=%0d last=%b",
                             k, plog[k].uop.vd, plog[k].uop.vs2, plog[k].last, 8 + k, 16 + k, (k == 7));
                end
            end
            vectors++;
            if (plog[7].rdy !== 1'b1 || plog[8].cyc != plog[7].cyc + 1) begin
                fails++;
                $display("FAIL lmul8_handoff: ready=%b gap=%0d, required 1/1", plog[7].rdy, plog[8].cyc - plog[7].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        plog.delete();
        dispatch(mk(2, 10, 20, 3'b001, FU_ALU));
        dispatch(mk(7, 11, 21, 3'b000, FU_LSU));
        drain();
        vectors++;
        if (plog.size() != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d parts, required 3", plog.size());
        end else begin
            vectors++;
            if (plog[1].cyc != plog[0].cyc + 1 || plog[2].cyc != plog[1].cyc + 1 ||
                plog[1].uop.vd !== 5'd3 || plog[2].uop.vd !== 5'd7 || plog[2].uop.fu !== FU_LSU ||
                plog[0].last !== 1'b0 || plog[1].last !== 1'b1 || plog[2].last !== 1'b1) begin
                fails++;
                $display("FAIL b2b_stream: cycles %0d,%0d,%0d vd %0d,%0d,%0d, required consecutive vd 2,3,7",
                         plog[0].cyc, plog[1].cyc, plog[2].cyc, plog[0].uop.vd, plog[1].uop.vd, plog[2].uop.vd);
            end
        end
    endtask

    task automatic test_backpressure();
        int b;
        plog.delete();
        b = $urandom_range(0, 28);
        fu_req_ready_i = 1'b0;
        toggle_rdy     = 1'b1;
        dispatch(mk(b, 28 - b, b / 2, 3'b010, FU_DIV));
        drain();
        toggle_rdy     = 1'b0;
        fu_req_ready_i = 1'b1;
        vectors++;
        if (plog.size() != 4) begin
            fails++;
            $display("FAIL bp_count: got %0d parts, required 4", plog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (plog[k].uop.vd !== 5'(b + k) || plog[k].uop.vs1 !== 5'(28 - b + k) ||
                    plog[k].uop.vs2 !== 5'(b / 2 + k) || plog[k].last !== (k == 3)) begin
                    fails++;
                    $display("FAIL bp_part%0d: vd=%0d last=%b, required vd=%0d last=%b",
                             k, plog[k].uop.vd, plog[k].last, b + k, (k == 3));
                end
            end
        end
    endtask

    task automatic test_cap();
        plog.delete();
        auto_done      = 1'b0;
        fu_done_i      = 1'b0;
        fu_req_ready_i = 1'b1;
        dispatch(mk(12, 13, 14, 3'b010, FU_ALU));
        repeat (4) tick();
        vectors++;
        if (plog.size() != 2 || fu_req_valid_o !== 1'b0 || outstanding_o !== OW'(2)) begin
            fails++;
            $display("FAIL cap_stall: parts=%0d valid=%b out=%0d, required 2/0/2", plog.size(), fu_req_valid_o, outstanding_o);
        end
        fu_done_i = 1'b1;
        tick();
        fu_done_i = 1'b0;
        tick();
        vectors++;
        if (plog.size() != 3 || outstanding_o !== OW'(2)) begin
            fails++;
            $display("FAIL cap_release: parts=%0d out=%0d, required 3/2", plog.size(), outstanding_o);
        end
        fu_done_i = 1'b1;
        repeat (2) tick();
        fu_done_i = 1'b0;
        vectors++;
        if (plog.size() != 4 || plog[plog.size()-1].last !== 1'b1 || outstanding_o !== OW'(1)) begin
            fails++;
            $display("FAIL cap_coincide: parts=%0d out=%0d, required 4/1", plog.size(), outstanding_o);
        end
        fu_done_i = 1'b1;
        repeat (2) tick();
        fu_done_i = 1'b0;
        tick();
        vectors++;
        if (outstanding_o !== '0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL cap_saturate: out=%0d busy=%b, required 0/0", outstanding_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        plog.delete();
        auto_done      = 1'b1;
        fu_req_ready_i = 1'b1;
        dispatch(mk(4, 5, 6, 3'b010, FU_MUL));
        repeat (2) tick();
        vectors++;
        if (plog.size() != 2) begin
            fails++;
            $display("FAIL rstmid_pre: parts=%0d, required 2", plog.size());
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        vectors++;
        if (fu_req_valid_o !== 1'b0 || outstanding_o !== '0 || dispatch_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_state: valid=%b out=%0d ready=%b, required 0/0/1", fu_req_valid_o, outstanding_o, dispatch_ready_o);
        end
        auto_done = 1'b0;
        fu_done_i = 1'b1;
        tick();
        fu_done_i = 1'b0;
        tick();
        vectors++;
        if (outstanding_o !== '0 || busy_o !== 1'b0 || plog.size() != 2) begin
            fails++;
            $display("FAIL rstmid_stray_done: out=%0d busy=%b parts=%0d, required 0/0/2", outstanding_o, busy_o, plog.size());
        end
        auto_done = 1'b1;
    endtask

    task automatic test_random();
        int total;
        plog.delete();
        total     = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] lm;
            int g;
            lm = 3'($urandom_range(0, 7));
            g  = n_groups(lm);
            total += g;
            repeat ($urandom_range(0, 2)) tick();
            dispatch(mk($urandom_range(0, 32 - g), $urandom_range(0, 32 - g),
                        $urandom_range(0, 32 - g), lm, fu_e'($urandom_range(0, 3))));
        end
        drain();
        rand_mode      = 1'b0;
        fu_req_ready_i = 1'b1;
        fu_done_i      = 1'b0;
        vectors++;
        if (plog.size() != total) begin
            fails++;
            $display("FAIL random_total: got %0d parts, required %0d", plog.size(), total);
        end
    endtask

    initial begin
        vectors          = 0;
        fails            = 0;
        cnt              = 0;
        cyc              = 0;
        rdy_low          = 0;
        hs_seen          = 1'b0;
        acc_seen         = 1'b0;
        auto_done        = 1'b1;
        toggle_rdy       = 1'b0;
        rand_mode        = 1'b0;
        rst_i            = 1'b1;
        dispatch_valid_i = 1'b0;
        dispatch_entry_i = '0;
        fu_req_ready_i   = 1'b1;
        fu_done_i        = 1'b0;
        test_reset();
        test_single();
        test_lmul8();
        test_back_to_back();
        test_backpressure();
        test_cap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
